// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default parameters for the ID-stage hazard scoreboard.
// Producer-kind encodings and the counter-width helper live here so every file agrees.
package hazard_scoreboard_pkg;

  localparam int HZ_NREG     = 32;
  localparam int HZ_RA_W     = 5;
  localparam int HZ_NSRC     = 2;
  localparam int HZ_LOAD_LAT = 2;
  localparam int HZ_CTRL_LAT = 1;

  localparam logic HZ_KIND_ALU  = 1'b0;
  localparam logic HZ_KIND_LOAD = 1'b1;

  function automatic int hz_lat_w(input int load_lat, input int ctrl_lat);
    int m;
    m = (load_lat > ctrl_lat) ? load_lat : ctrl_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int HZ_LAT_W = hz_lat_w(HZ_LOAD_LAT, HZ_CTRL_LAT);

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard unit bundle: decode fields in, stall/busy status out.
// master = decode/pipeline-control side, slave = hazard_scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = HZ_NREG,
  parameter int RA_W = HZ_RA_W,
  parameter int NSRC = HZ_NSRC
);

  logic                   id_valid;
  logic [NSRC*RA_W-1:0]   id_rs;
  logic [NSRC-1:0]        id_rs_used;
  logic                   id_is_ctrl;
  logic [RA_W-1:0]        id_rd;
  logic                   id_regwrite;
  logic                   id_memread;
  logic                   flush;
  logic                   ex_kill;
  logic                   stall;
  logic                   stall_load;
  logic                   stall_ctrl;
  logic [NREG-1:0]        busy_mask;

  modport master (
    output id_valid, id_rs, id_rs_used, id_is_ctrl, id_rd, id_regwrite, id_memread,
           flush, ex_kill,
    input  stall, stall_load, stall_ctrl, busy_mask
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_is_ctrl, id_rd, id_regwrite, id_memread,
           flush, ex_kill,
    output stall, stall_load, stall_ctrl, busy_mask
  );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot (hz_sb_entry): remaining unsafe cycles plus producer kind.
// Priority inside the slot: load > kill > decrement.
module hz_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = HZ_LAT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [LAT_W-1:0] load_cnt,
  input  logic             load_kind,
  input  logic             kill,
  input  logic             dec,
  output logic             busy,
  output logic             ld
);

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (load) begin
      cnt_d = load_cnt;
      // a zero-latency producer never owes anything, so it is never marked as a load
      ld_d  = (load_kind == HZ_KIND_LOAD) && (load_cnt != '0);
    end else if (kill) begin
      cnt_d = '0;
      ld_d  = 1'b0;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_W'(1);
      if (cnt_q == LAT_W'(1)) ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign ld   = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit with a per-register countdown scoreboard (load-use and ALU->branch stalls).
// Optional performance counters are built only when HZ_PERF_EN is defined.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG     = HZ_NREG,
  parameter int RA_W     = HZ_RA_W,
  parameter int NSRC     = HZ_NSRC,
  parameter int LOAD_LAT = HZ_LOAD_LAT,
  parameter int CTRL_LAT = HZ_CTRL_LAT
) (
  input  logic                clk,
  input  logic                rstn,
  hazard_scoreboard_if.slave  hz,
  output logic [31:0]         perf_stall_cyc,
  output logic [31:0]         perf_lu_evt
);

  localparam int LAT_W = hz_lat_w(LOAD_LAT, CTRL_LAT);
  localparam int NADDR = 1 << RA_W;

  logic [NREG-1:0]  busy_vec;
  logic [NREG-1:0]  ld_vec;
  logic [NADDR-1:0] busy_ext;
  logic [NADDR-1:0] ld_ext;
  logic [RA_W-1:0]  src_rs [NSRC];
  logic [NSRC-1:0]  src_hit;
  logic [NSRC-1:0]  src_ld;

  logic             stall_load;
  logic             stall_ctrl;
  logic             stall;
  logic             issue;
  logic [LAT_W-1:0] load_cnt;

  logic             last_v_q, last_v_d;
  logic [RA_W-1:0]  last_rd_q, last_rd_d;

  // addresses beyond NREG read as idle
  assign busy_ext = NADDR'(busy_vec);
  assign ld_ext   = NADDR'(ld_vec);

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_rs[i]  = hz.id_rs[i*RA_W +: RA_W];
    assign src_hit[i] = hz.id_valid & hz.id_rs_used[i] & (src_rs[i] != '0) & busy_ext[src_rs[i]];
    assign src_ld[i]  = ld_ext[src_rs[i]];
  end

  assign stall_load = |(src_hit & src_ld);
  assign stall_ctrl = (|(src_hit & ~src_ld)) & hz.id_is_ctrl;
  assign stall      = stall_load | stall_ctrl;

  assign issue    = hz.id_valid & hz.id_regwrite & (hz.id_rd != '0) & ~hz.flush & ~stall;
  assign load_cnt = hz.id_memread ? LAT_W'(LOAD_LAT) : LAT_W'(CTRL_LAT);

  assign busy_vec[0] = 1'b0;
  assign ld_vec[0]   = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hz_sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk       (clk),
      .rstn      (rstn),
      .load      (issue && (hz.id_rd == RA_W'(r))),
      .load_cnt  (load_cnt),
      .load_kind (hz.id_memread),
      .kill      (hz.ex_kill && last_v_q && (last_rd_q == RA_W'(r))),
      .dec       (1'b1),
      .busy      (busy_vec[r]),
      .ld        (ld_vec[r])
    );
  end

  always_comb begin
    last_v_d  = issue;
    last_rd_d = hz.id_rd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_v_q  <= 1'b0;
      last_rd_q <= '0;
    end else begin
      last_v_q  <= last_v_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign hz.stall      = stall;
  assign hz.stall_load = stall_load;
  assign hz.stall_ctrl = stall_ctrl;
  assign hz.busy_mask  = busy_vec;

`ifdef HZ_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_lu_q, perf_lu_d;
  logic        sl_prev_q, sl_prev_d;

  always_comb begin
    perf_stall_d = perf_stall_q + 32'(stall);
    perf_lu_d    = perf_lu_q + 32'(stall_load & ~sl_prev_q);
    sl_prev_d    = stall_load;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
      sl_prev_q    <= 1'b0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_lu_q    <= perf_lu_d;
      sl_prev_q    <= sl_prev_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_lu_evt    = perf_lu_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_lu_evt    = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations into a queue,
// a monitor pops and compares them on each falling clock edge (or on demand for async reset).
module tb_hazard_scoreboard;

  typedef struct {
    string       nm;
    logic        st;
    logic        sl;
    logic        sc;
    logic [31:0] busy;
    bit          chk_perf;
    int          ps;
    int          pl;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_lu_evt;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  event mon_ev;

  hazard_scoreboard_if #(.NREG(32), .RA_W(5), .NSRC(2)) hz_if ();

  hazard_scoreboard #(
    .NREG(32), .RA_W(5), .NSRC(2), .LOAD_LAT(2), .CTRL_LAT(1)
  ) u_dut (
    .clk            (clk),
    .rstn           (rstn),
    .hz             (hz_if),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_lu_evt    (perf_lu_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, "_stall"}, 32'(hz_if.stall), 32'(e.st));
        chk({e.nm, "_stall_load"}, 32'(hz_if.stall_load), 32'(e.sl));
        chk({e.nm, "_stall_ctrl"}, 32'(hz_if.stall_ctrl), 32'(e.sc));
        chk({e.nm, "_busy"}, hz_if.busy_mask, e.busy);
`ifdef HZ_PERF_EN
        if (e.chk_perf) begin
          chk({e.nm, "_perf_stall"}, perf_stall_cyc, 32'(e.ps));
          chk({e.nm, "_perf_lu"}, perf_lu_evt, 32'(e.pl));
        end
`else
        chk({e.nm, "_perf_stall"}, perf_stall_cyc, 32'd0);
        chk({e.nm, "_perf_lu"}, perf_lu_evt, 32'd0);
`endif
      end
    end
  end

  task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] u,
                       input bit c, input int rd, input bit rw, input bit mr,
                       input bit fl, input bit kl);
    hz_if.id_valid    = v;
    hz_if.id_rs       = {5'(rs1), 5'(rs0)};
    hz_if.id_rs_used  = u;
    hz_if.id_is_ctrl  = c;
    hz_if.id_rd       = 5'(rd);
    hz_if.id_regwrite = rw;
    hz_if.id_memread  = mr;
    hz_if.flush       = fl;
    hz_if.ex_kill     = kl;
  endtask

  function automatic exp_t mk(input string nm, input bit st, input bit sl, input bit sc,
                              input logic [31:0] busy, input bit cp, input int ps, input int pl);
    exp_t e;
    e.nm = nm; e.st = st; e.sl = sl; e.sc = sc; e.busy = busy;
    e.chk_perf = cp; e.ps = ps; e.pl = pl;
    return e;
  endfunction

  // one ID cycle: inputs applied just after the rising edge, checked on the falling edge
  task automatic step(input string nm, input bit v, input int rs0, input int rs1,
                      input bit [1:0] u, input bit c, input int rd, input bit rw, input bit mr,
                      input bit fl, input bit kl,
                      input bit est, input bit esl, input bit esc, input logic [31:0] eb,
                      input bit cp = 1'b0, input int ps = 0, input int pl = 0);
    drive(v, rs0, rs1, u, c, rd, rw, mr, fl, kl);
    q.push_back(mk(nm, est, esl, esc, eb, cp, ps, pl));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] eb, input bit kl = 1'b0,
                      input bit cp = 1'b0, input int ps = 0, input int pl = 0);
    step(nm, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, kl, 0, 0, 0, eb, cp, ps, pl);
  endtask

  function automatic logic [31:0] bm(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    idle("rst", 32'd0, 0, 1, 0, 0);
    rstn = 1'b1;

    // T1: lw x5 ; add x6,x5,x1
    step("t1_lw",    1, 1, 0, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("t1_use1",  1, 5, 1, 2'b11, 0, 6, 1, 0, 0, 0, 1, 1, 0, bm(5));
    step("t1_use2",  1, 5, 1, 2'b11, 0, 6, 1, 0, 0, 0, 1, 1, 0, bm(5));
    step("t1_go",    1, 5, 1, 2'b11, 0, 6, 1, 0, 0, 0, 0, 0, 0, 32'd0);
    idle("t1_idle1", bm(6));
    idle("t1_idle2", 32'd0, 0, 1, 2, 1);

    // T2: addi x7 ; beq x7,x0 then addi x7 ; add x8,x7,x1
    step("t2_addi",   1, 1, 0, 2'b01, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'd0);
    step("t2_beq",    1, 7, 0, 2'b11, 1, 0, 0, 0, 0, 0, 1, 0, 1, bm(7));
    step("t2_beq_go", 1, 7, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    step("t2_addi2",  1, 1, 0, 2'b01, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'd0);
    step("t2_add",    1, 7, 1, 2'b11, 0, 8, 1, 0, 0, 0, 0, 0, 0, bm(7));
    idle("t2_idle1", bm(8));
    idle("t2_idle2", 32'd0);

    // T3: x0 never tracked; unused source slots never stall
    step("t3_lw_x0",  1, 1, 0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("t3_use_x0", 1, 0, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    step("t3_lw_x9",  1, 1, 0, 2'b01, 0, 9, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("t3_unused", 1, 9, 9, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, bm(9));
    idle("t3_idle1", bm(9));
    idle("t3_idle2", 32'd0);

    // flushed writer is not recorded
    step("fl_lw",  1, 1, 0, 2'b01, 0, 10, 1, 1, 1, 0, 0, 0, 0, 32'd0);
    step("fl_use", 1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);

    // stall and flush together: stall still reported, nothing issued
    step("sf_lw",    1, 1, 0, 2'b01, 0, 14, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("sf_flush", 1, 14, 0, 2'b01, 0, 15, 1, 0, 1, 0, 1, 1, 0, bm(14));
    idle("sf_idle1", bm(14));
    idle("sf_idle2", 32'd0);

    // T4: lw x5 then ex_kill
    step("t4_lw",  1, 1, 0, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    idle("t4_kill", bm(5), 1);
    step("t4_use", 1, 5, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);

    // kill and a fresh issue to the same register: the issue wins
    step("kb_lw",   1, 1, 0, 2'b01, 0, 11, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("kb_relw", 1, 1, 0, 2'b01, 0, 11, 1, 1, 0, 1, 0, 0, 0, bm(11));
    idle("kb_idle1", bm(11));
    idle("kb_idle2", bm(11));
    idle("kb_idle3", 32'd0);

    // T5: lw x5 ; addi x5 overwrites with ALU latency ; beq x5
    step("t5_lw",     1, 1, 0, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("t5_addi",   1, 1, 0, 2'b01, 0, 5, 1, 0, 0, 0, 0, 0, 0, bm(5));
    step("t5_beq",    1, 5, 0, 2'b11, 1, 0, 0, 0, 0, 0, 1, 0, 1, bm(5));
    step("t5_beq_go", 1, 5, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);

    // both sources hit: load on x12, ALU on x13, consumer is a branch
    step("d_lw12",   1, 1, 0, 2'b01, 0, 12, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("d_addi13", 1, 1, 0, 2'b01, 0, 13, 1, 0, 0, 0, 0, 0, 0, bm(12));
    step("d_beq",    1, 12, 13, 2'b11, 1, 0, 0, 0, 0, 0, 1, 1, 1, bm(12) | bm(13));
    step("d_beq_go", 1, 12, 13, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);

    // T6: reset in the middle of a load countdown, consumer still in ID
    step("t6_lw",  1, 1, 0, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0, 32'd0);
    step("t6_use", 1, 5, 1, 2'b11, 0, 6, 1, 0, 0, 0, 1, 1, 0, bm(5));
    #2;
    rstn = 1'b0;
    #1;
    q.push_back(mk("t6_async", 0, 0, 0, 32'd0, 1, 0, 0));
    ->mon_ev;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step("t6_after", 1, 5, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0, 0);

    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
